i_mem_loader: RTL
=================

// Module: i_mem_loader
// PURPOSE
//   Writer side of the instruction-memory interface. Receives a program image as a
//   byte stream (valid/ready) and assembles big-endian 32-bit words. Writes each word
//   through a word-wide write port at byte address 4*i, the same addressing the fetch
//   path reads with (index = address>>2).
//   Holds the CPU in reset-like stall (cpu_hold) while loading. Sits between a host
//   link (UART/testbench) and the writable instruction memory.
// PARAMETERS
//   DEPTH    256  instruction words in memory; maximum accepted image length
//   CNT_W    16   width of the length header (words), big-endian on the stream
// PORTS
//   clk         in   1   single clock; all state changes on rising edge
//   rst_n       in   1   synchronous, active-low reset
//   start       in   1   one-cycle request to begin a load
//   byte_in     in   8   stream data byte
//   byte_valid  in   1   byte_in valid
//   byte_ready  out  1   loader accepts byte this cycle (transfer = valid & ready)
//   wr_en       out  1   one-cycle instruction-memory write strobe
//   wr_addr     out  32  byte address of written word (= 4*index)
//   wr_data     out  32  assembled instruction word
//   cpu_hold    out  1   high while a load is in progress; CPU must not fetch
//   done        out  1   level; high after a complete successful load
//   error       out  1   level; high after a rejected header (length > DEPTH)
//   words_done  out  CNT_W  count of words written in current/last load
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state IDLE, all outputs 0, counters/shift reg cleared.
//     Reset mid-load aborts immediately. A partial word is discarded. Words already
//     written stay in memory.
//   States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
//   IDLE/DONE/ERROR: byte_ready=0. On start, -> LEN_HI, clear done/error/words_done,
//     set cpu_hold=1. start in any other state is ignored.
//   LEN_HI: byte_ready=1; accepted byte -> len[15:8]; -> LEN_LO.
//   LEN_LO: byte_ready=1; accepted byte -> len[7:0]. Next state decided on that byte:
//     len==0      -> DONE.
//     len>DEPTH   -> ERROR. No writes are issued.
//     otherwise   -> DATA.
//   DATA: byte_ready=1; accepted bytes are shifted in MSB-first (first byte -> [31:24]).
//     On the 4th accepted byte -> WRITE.
//   WRITE: byte_ready=0 and wr_en=1 for exactly this cycle, with
//     wr_addr = words_done<<2 and wr_data = the assembled word.
//     At the edge ending WRITE, words_done increments.
//     -> DONE if words_done+1==len, else -> DATA.
//   DONE: done=1, cpu_hold=0. ERROR: error=1, cpu_hold=0. Both hold until start or reset.
//   Latency: wr_en is asserted in the cycle after the 4th byte of each word is accepted.
//     Max throughput is 4 bytes per 5 cycles.
//   byte_valid with byte_ready=0: byte is not consumed; the source must hold it.
//   Gaps in byte_valid are allowed anywhere; no timeout.
//   wr_addr/wr_data hold their last values outside WRITE; only wr_en qualifies them.
//   Len==DEPTH is legal: the last address is 4*(DEPTH-1). No wrap-around is possible.
// TESTING
//   1. Reset, start, stream 00 02 | 20 08 00 05 | AC 08 00 04 ->
//      two wr_en pulses: (0x0,0x20080005) then (0x4,0xAC080004); done=1; cpu_hold falls.
//   2. Header 00 00 -> DONE with no wr_en pulse, words_done=0, done=1.
//   3. Header 01 01 (257 > DEPTH) -> ERROR: error=1, no wr_en, byte_ready=0 afterwards.
//   4. Header 01 00, 1024 bytes with random valid gaps -> 256 writes, last at 0x3FC.
//      Verify byte_ready=0 on every WRITE cycle and that no byte is lost.
//   5. rst_n=0 after 2 of 4 data bytes -> IDLE, outputs 0. New start + 1-word image
//      writes address 0x0 with the fresh word only.
//   6. start pulsed during DATA -> ignored: load completes unchanged, words_done=len.

Source files
------------

// File: rtl/i_mem_loader.sv
// Instruction-memory loader: turns a length-prefixed big-endian byte stream into
// word writes at byte address 4*i, holding the CPU off while the image arrives.
module i_mem_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

    state_t           state_r;
    logic [CNT_W-1:0] len_r;
    logic [23:0]      shift_r;
    logic [1:0]       byte_cnt_r;
    logic [CNT_W-1:0] len_new_s;
    logic [CNT_W-1:0] words_next_s;
    logic             take_s;

    assign take_s       = byte_valid & byte_ready;
    assign len_new_s    = {len_r[CNT_W-1:8], byte_in};
    assign words_next_s = words_done + CNT_W'(1);

    // Load sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            len_r      <= '0;
            shift_r    <= 24'd0;
            byte_cnt_r <= 2'd0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_r    <= ST_LEN_HI;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        words_done <= '0;
                        cpu_hold   <= 1'b1;
                        byte_ready <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LEN_HI: begin
                    if (take_s) begin
                        len_r[CNT_W-1:8] <= byte_in;
                        state_r          <= ST_LEN_LO;
                    end else begin
                        state_r <= ST_LEN_HI;
                    end
                end
                ST_LEN_LO: begin
                    if (take_s) begin
                        len_r <= len_new_s;
                        if (len_new_s == '0) begin
                            state_r    <= ST_DONE;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
                            byte_ready <= 1'b0;
                        end else if (len_new_s > DEPTH_L) begin
                            // Oversized image: reject before any memory is touched.
                            state_r    <= ST_ERROR;
                            error      <= 1'b1;
                            cpu_hold   <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state_r    <= ST_DATA;
                            byte_cnt_r <= 2'd0;
                        end
                    end else begin
                        state_r <= ST_LEN_LO;
                    end
                end
                ST_DATA: begin
                    if (take_s) begin
                        shift_r    <= {shift_r[15:0], byte_in};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            state_r    <= ST_WRITE;
                            byte_ready <= 1'b0;
                            wr_en      <= 1'b1;
                            wr_addr    <= {{(32-CNT_W-2){1'b0}}, words_done, 2'b00};
                            wr_data    <= {shift_r, byte_in};
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_WRITE: begin
                    wr_en      <= 1'b0;
                    words_done <= words_next_s;
                    byte_cnt_r <= 2'd0;
                    if (words_next_s == len_r) begin
                        state_r    <= ST_DONE;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
                        byte_ready <= 1'b0;
                    end else begin
                        state_r    <= ST_DATA;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    byte_ready <= 1'b0;
                    wr_en      <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

endmodule
